// File: rtl/apb_cmd_requester.sv
// APB requester: buffers up to two read/write commands and runs them as APB SETUP/ACCESS transfers.
// Optional ACCESS-phase abort counter is enabled by defining APB_TIMEOUT_EN.
module apb_cmd_requester #(
  parameter int AW             = 8,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_write,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [DW-1:0]   cmd_wdata,
  input  logic [DW/8-1:0] cmd_strb,
  output logic            rsp_valid,
  output logic [DW-1:0]   rsp_rdata,
  output logic            rsp_err,
  output logic            psel,
  output logic            penable,
  output logic            pwrite,
  output logic [AW-1:0]   pwaddr,
  output logic [DW-1:0]   pwdata,
  output logic [DW/8-1:0] pstrb,
  input  logic            pready,
  input  logic [DW-1:0]   prdata,
  input  logic            pslverr,
  input  logic            irq_clr,
  output logic            interrupt
);

  localparam int SW = DW / 8;
  localparam int EW = 1 + AW + DW + SW;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t          state;
  logic [EW-1:0]   mem [2];
  logic            wr_ptr;
  logic            rd_ptr;
  logic [1:0]      count;
  logic            push;
  logic            pop;
  logic            done;
  logic            timeout;
  logic            err_evt;
  logic            more;
  logic            ld_write;
  logic [AW-1:0]   ld_addr;
  logic [DW-1:0]   ld_wdata;
  logic [SW-1:0]   ld_strb;

  assign cmd_ready = (count != 2'd2);
  assign push      = cmd_valid && cmd_ready;
  assign done      = (state == ACCESS) && pready;
  assign pop       = done || timeout;
  assign err_evt   = timeout || (done && pslverr);
  // A second entry already held means the next transfer can start without returning to IDLE.
  assign more      = (count == 2'd2);

  // IDLE launches the head entry; a back-to-back launch from ACCESS takes the entry behind it.
  assign {ld_write, ld_addr, ld_wdata, ld_strb} = (state == IDLE) ? mem[rd_ptr] : mem[~rd_ptr];

`ifdef APB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;

  assign timeout = (state == ACCESS) && !pready && (tcnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt <= '0;
    end else if (state == SETUP) begin
      tcnt <= '0;
    end else if ((state == ACCESS) && !pready) begin
      tcnt <= tcnt + TW'(1);
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Command storage is data only and needs no reset; validity lives in count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_write, cmd_addr, cmd_wdata, cmd_strb};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      pwaddr    <= '0;
      pwdata    <= '0;
      pstrb     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      interrupt <= 1'b0;
    end else begin
      rsp_valid <= pop;
      rsp_err   <= err_evt;
      rsp_rdata <= (done && !pwrite) ? prdata : '0;

      if (err_evt)      interrupt <= 1'b1;
      else if (irq_clr) interrupt <= 1'b0;

      case (state)
        IDLE: begin
          if (count != 2'd0) begin
            state   <= SETUP;
            psel    <= 1'b1;
            penable <= 1'b0;
            pwrite  <= ld_write;
            pwaddr  <= ld_addr;
            pwdata  <= ld_wdata;
            pstrb   <= ld_write ? ld_strb : '0;
          end
        end
        SETUP: begin
          state   <= ACCESS;
          penable <= 1'b1;
        end
        ACCESS: begin
          if (pop) begin
            penable <= 1'b0;
            if (more) begin
              state  <= SETUP;
              pwrite <= ld_write;
              pwaddr <= ld_addr;
              pwdata <= ld_wdata;
              pstrb  <= ld_write ? ld_strb : '0;
            end else begin
              state <= IDLE;
              psel  <= 1'b0;
            end
          end
        end
        default: begin
          state   <= IDLE;
          psel    <= 1'b0;
          penable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_cmd_requester.sv
// Directed bench for apb_cmd_requester; define APB_TIMEOUT_EN on both files to add the abort case.
module tb_apb_cmd_requester;

  localparam int AW = 8;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_write;
  logic [AW-1:0]   cmd_addr;
  logic [DW-1:0]   cmd_wdata;
  logic [DW/8-1:0] cmd_strb;
  logic            rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic            psel;
  logic            penable;
  logic            pwrite;
  logic [AW-1:0]   pwaddr;
  logic [DW-1:0]   pwdata;
  logic [DW/8-1:0] pstrb;
  logic            pready;
  logic [DW-1:0]   prdata;
  logic            pslverr;
  logic            irq_clr;
  logic            interrupt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  apb_cmd_requester #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .pwaddr(pwaddr),
    .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .prdata(prdata),
    .pslverr(pslverr), .irq_clr(irq_clr), .interrupt(interrupt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic offer(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [DW/8-1:0] s);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_strb  = s;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_strb = '0; pready = 1'b0; prdata = '0; pslverr = 1'b0; irq_clr = 1'b0;
    repeat (3) cyc();
    chk("rst_psel", psel, 1'b0);
    chk("rst_penable", penable, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_interrupt", interrupt, 1'b0);
    rst = 1'b0;
    cyc();
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_pstrb", pstrb, 4'h0);

    // Zero-wait write
    pready = 1'b1;
    offer(1'b1, 8'h10, 32'hDEADBEEF, 4'hF);
    cyc();
    cmd_valid = 1'b0;
    chk("wr_n0_psel", psel, 1'b0);
    cyc();
    chk("wr_setup_psel", psel, 1'b1);
    chk("wr_setup_penable", penable, 1'b0);
    chk("wr_setup_pwaddr", pwaddr, 8'h10);
    chk("wr_setup_pwrite", pwrite, 1'b1);
    chk("wr_setup_pwdata", pwdata, 32'hDEADBEEF);
    chk("wr_setup_pstrb", pstrb, 4'hF);
    cyc();
    chk("wr_access_psel", psel, 1'b1);
    chk("wr_access_penable", penable, 1'b1);
    chk("wr_access_rsp", rsp_valid, 1'b0);
    cyc();
    chk("wr_done_psel", psel, 1'b0);
    chk("wr_done_penable", penable, 1'b0);
    chk("wr_rsp_valid", rsp_valid, 1'b1);
    chk("wr_rsp_err", rsp_err, 1'b0);
    chk("wr_rsp_rdata", rsp_rdata, 32'h0);
    cyc();
    chk("wr_rsp_pulse", rsp_valid, 1'b0);

    // Read with three wait states
    pready = 1'b0;
    prdata = 32'h1234;
    offer(1'b0, 8'h20, 32'hFFFF_FFFF, 4'hF);
    cyc();
    cmd_valid = 1'b0;
    cyc();
    chk("rd_setup_pwrite", pwrite, 1'b0);
    chk("rd_setup_pstrb", pstrb, 4'h0);
    cyc();
    chk("rd_access_penable", penable, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rd_wait_pwaddr", pwaddr, 8'h20);
      chk("rd_wait_pstrb", pstrb, 4'h0);
      chk("rd_wait_penable", penable, 1'b1);
      chk("rd_wait_rsp", rsp_valid, 1'b0);
    end
    pready = 1'b1;
    cyc();
    pready = 1'b0;
    chk("rd_rsp_valid", rsp_valid, 1'b1);
    chk("rd_rsp_rdata", rsp_rdata, 32'h1234);
    chk("rd_rsp_err", rsp_err, 1'b0);
    chk("rd_done_penable", penable, 1'b0);

    // Three back-to-back commands against a stalled completer
    cyc();
    offer(1'b1, 8'h30, 32'hA0, 4'h1);
    cyc();
    chk("b2b_ready_1", cmd_ready, 1'b1);
    offer(1'b1, 8'h31, 32'hA1, 4'h3);
    cyc();
    chk("b2b_full", cmd_ready, 1'b0);
    chk("b2b_a_pwaddr", pwaddr, 8'h30);
    chk("b2b_a_psel", psel, 1'b1);
    offer(1'b1, 8'h32, 32'hA2, 4'h7);
    cyc();
    chk("b2b_a_penable", penable, 1'b1);
    chk("b2b_full_2", cmd_ready, 1'b0);
    cyc();
    chk("b2b_full_3", cmd_ready, 1'b0);
    pready = 1'b1;
    cyc();
    pready = 1'b0;
    chk("b2b_b_psel", psel, 1'b1);
    chk("b2b_b_penable", penable, 1'b0);
    chk("b2b_b_pwaddr", pwaddr, 8'h31);
    chk("b2b_b_pstrb", pstrb, 4'h3);
    chk("b2b_a_rsp", rsp_valid, 1'b1);
    chk("b2b_ready_after_pop", cmd_ready, 1'b1);
    cyc();
    cmd_valid = 1'b0;
    chk("b2b_b_access", penable, 1'b1);
    chk("b2b_c_held", cmd_ready, 1'b0);
    pready = 1'b1;
    cyc();
    chk("b2b_c_pwaddr", pwaddr, 8'h32);
    chk("b2b_c_psel", psel, 1'b1);
    chk("b2b_c_penable", penable, 1'b0);
    cyc();
    cyc();
    pready = 1'b0;
    chk("b2b_drain_psel", psel, 1'b0);
    chk("b2b_c_rsp", rsp_valid, 1'b1);

    // Slave error, interrupt and clear priority
    pready = 1'b1;
    pslverr = 1'b1;
    prdata = 32'h55;
    offer(1'b0, 8'h40, 32'h0, 4'hF);
    cyc();
    cmd_valid = 1'b0;
    cyc();
    cyc();
    cyc();
    chk("err_rsp_valid", rsp_valid, 1'b1);
    chk("err_rsp_err", rsp_err, 1'b1);
    chk("err_interrupt", interrupt, 1'b1);
    pslverr = 1'b0;
    cyc();
    chk("err_irq_sticky", interrupt, 1'b1);
    chk("err_rsp_err_clear", rsp_err, 1'b0);
    irq_clr = 1'b1;
    cyc();
    irq_clr = 1'b0;
    chk("irq_cleared", interrupt, 1'b0);
    pslverr = 1'b1;
    offer(1'b0, 8'h41, 32'h0, 4'hF);
    cyc();
    cmd_valid = 1'b0;
    cyc();
    cyc();
    irq_clr = 1'b1;
    cyc();
    irq_clr = 1'b0;
    pslverr = 1'b0;
    chk("irq_set_wins", interrupt, 1'b1);
    chk("irq_set_wins_err", rsp_err, 1'b1);

    // Reset during ACCESS with a second command queued
    pready = 1'b0;
    offer(1'b1, 8'h50, 32'h50, 4'hF);
    cyc();
    offer(1'b1, 8'h51, 32'h51, 4'hF);
    cyc();
    cmd_valid = 1'b0;
    cyc();
    chk("rst_mid_penable_pre", penable, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_mid_psel", psel, 1'b0);
    chk("rst_mid_penable", penable, 1'b0);
    chk("rst_mid_irq", interrupt, 1'b0);
    cyc();
    cyc();
    rst = 1'b0;
    pready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("rst_flush_psel", psel, 1'b0);
      chk("rst_flush_rsp", rsp_valid, 1'b0);
    end
    chk("rst_flush_ready", cmd_ready, 1'b1);
    pready = 1'b0;

`ifdef APB_TIMEOUT_EN
    // Completer never responds; the transfer is aborted after 16 ACCESS cycles
    prdata = 32'hABCD;
    offer(1'b0, 8'h60, 32'h0, 4'hF);
    cyc();
    cmd_valid = 1'b0;
    cyc();
    cyc();
    chk("to_access", penable, 1'b1);
    for (int i = 0; i < 15; i++) begin
      cyc();
      chk("to_wait_rsp", rsp_valid, 1'b0);
      chk("to_wait_penable", penable, 1'b1);
    end
    cyc();
    chk("to_rsp_valid", rsp_valid, 1'b1);
    chk("to_rsp_err", rsp_err, 1'b1);
    chk("to_rsp_rdata", rsp_rdata, 32'h0);
    chk("to_interrupt", interrupt, 1'b1);
    chk("to_psel", psel, 1'b0);
    chk("to_penable", penable, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
